video_src_gen: RTL and testbench

VIDEO_SRC_GEN -- requirements
Module: video_src_gen

---
 rtl/video_src_gen.sv | 219 +++++++++++++++++++++
 tb/tb_video_src_gen.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/video_src_gen.sv
// video_src_gen: programmable video timing and test-pattern source.
//
// Walks a column/line raster sized by the latched timing inputs and emits sync,
// data-enable and RGB with one register stage after the counters. Region order
// on both axes is sync, back porch, active, front porch; zero-width regions
// simply never match.
//
// Ports
//   clk_i            pixel clock, rising edge
//   rst_i            asynchronous reset, active low
//   en_i             generation enable, sampled at frame boundaries
//   H_sync..H_FP     horizontal region widths in pixels
//   V_sync..V_FP     vertical region widths in lines
//   pattern_sel_i    0 solid, 1 colour bars, 2 gradient, 3 checker
//   color_i          solid colour {R,G,B}
//   hsync_o, vsync_o active-high syncs
//   de_o             active video
//   red_o..blue_o    pixel data, zero outside active video
//   frame_done_o     pulse aligned with the last pixel of a frame
//   frame_cnt_o      completed frames
//
// Build option: define VIDEO_SRC_FRAME_CNT_EN to implement frame_cnt_o;
// otherwise it is tied to zero.
module video_src_gen (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic [9:0]  H_sync,
    input  logic [9:0]  H_BP,
    input  logic [9:0]  H_VldDat,
    input  logic [9:0]  H_FP,
    input  logic [9:0]  V_sync,
    input  logic [9:0]  V_BP,
    input  logic [9:0]  V_VldDat,
    input  logic [9:0]  V_FP,
    input  logic [1:0]  pattern_sel_i,
    input  logic [23:0] color_i,
    output logic        hsync_o,
    output logic        vsync_o,
    output logic        de_o,
    output logic [7:0]  red_o,
    output logic [7:0]  green_o,
    output logic [7:0]  blue_o,
    output logic        frame_done_o,
    output logic [15:0] frame_cnt_o
);

    typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

    state_e      state_q, state_d;
    logic [9:0]  h_sync_q, h_bp_q, h_act_q, h_fp_q;
    logic [9:0]  v_sync_q, v_bp_q, v_act_q, v_fp_q;
    logic [1:0]  pattern_q;
    logic [23:0] color_q;
    logic [11:0] col_q, col_d, line_q, line_d;

    logic [11:0] h_act_start, h_act_end, h_total;
    logic [11:0] v_act_start, v_act_end, v_total;

    assign h_act_start = {2'b0, h_sync_q} + {2'b0, h_bp_q};
    assign h_act_end   = h_act_start + {2'b0, h_act_q};
    assign h_total     = h_act_end + {2'b0, h_fp_q};
    assign v_act_start = {2'b0, v_sync_q} + {2'b0, v_bp_q};
    assign v_act_end   = v_act_start + {2'b0, v_act_q};
    assign v_total     = v_act_end + {2'b0, v_fp_q};

    logic running, start_ok, col_last, last_pix, latch_en;

    assign running  = (state_q != StIdle);
    // Decided on the live inputs, which are latched on the same edge.
    assign start_ok = en_i && (H_VldDat != 10'd0) && (V_VldDat != 10'd0);
    assign col_last = (col_q == h_total - 12'd1);
    assign last_pix = running && col_last && (line_q == v_total - 12'd1);
    // Counters sit at (0,0) in idle and after the last pixel: both are frame start.
    assign latch_en = !running || last_pix;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            h_sync_q  <= '0;
            h_bp_q    <= '0;
            h_act_q   <= '0;
            h_fp_q    <= '0;
            v_sync_q  <= '0;
            v_bp_q    <= '0;
            v_act_q   <= '0;
            v_fp_q    <= '0;
            pattern_q <= '0;
            color_q   <= '0;
        end else if (latch_en) begin
            h_sync_q  <= H_sync;
            h_bp_q    <= H_BP;
            h_act_q   <= H_VldDat;
            h_fp_q    <= H_FP;
            v_sync_q  <= V_sync;
            v_bp_q    <= V_BP;
            v_act_q   <= V_VldDat;
            v_fp_q    <= V_FP;
            pattern_q <= pattern_sel_i;
            color_q   <= color_i;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start_ok) state_d = StRun;
            StRun: begin
                if (last_pix)   state_d = start_ok ? StRun : StIdle;
                else if (!en_i) state_d = StDrain;
            end
            StDrain: begin
                if (last_pix)  state_d = start_ok ? StRun : StIdle;
                else if (en_i) state_d = StRun;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        col_d  = col_q;
        line_d = line_q;
        if (latch_en) begin
            col_d  = '0;
            line_d = '0;
        end else if (col_last) begin
            col_d  = '0;
            line_d = line_q + 12'd1;
        end else begin
            col_d  = col_q + 12'd1;
        end
    end

    logic        hsync_c, vsync_c, de_c;
    logic [11:0] act_col, bar_w, bar_edge;
    logic [4:0]  act_line;
    logic [3:0]  bar_idx;
    logic [23:0] bar_rgb, rgb_c;

    always_comb begin
        hsync_c  = running && (col_q < {2'b0, h_sync_q});
        vsync_c  = running && (line_q < {2'b0, v_sync_q});
        de_c     = running && (col_q >= h_act_start) && (col_q < h_act_end) &&
                   (line_q >= v_act_start) && (line_q < v_act_end);
        act_col  = col_q - h_act_start;
        // Only bit 4 of the active line is needed; low bits of a difference
        // depend only on low bits of the operands.
        act_line = line_q[4:0] - v_act_start[4:0];

        // Bar index = number of bar boundaries passed; index 8 is the remainder.
        bar_w    = {5'b0, h_act_q[9:3]};
        bar_edge = '0;
        bar_idx  = '0;
        for (int k = 0; k < 8; k++) begin
            bar_edge = bar_edge + bar_w;
            if (act_col >= bar_edge) bar_idx = bar_idx + 4'd1;
        end
        case (bar_idx)
            4'd0:    bar_rgb = 24'hFFFFFF;
            4'd1:    bar_rgb = 24'hFFFF00;
            4'd2:    bar_rgb = 24'h00FFFF;
            4'd3:    bar_rgb = 24'h00FF00;
            4'd4:    bar_rgb = 24'hFF00FF;
            4'd5:    bar_rgb = 24'hFF0000;
            4'd6:    bar_rgb = 24'h0000FF;
            default: bar_rgb = 24'h000000;
        endcase

        rgb_c = '0;
        if (de_c) begin
            case (pattern_q)
                2'd0:    rgb_c = color_q;
                2'd1:    rgb_c = bar_rgb;
                2'd2:    rgb_c = {act_col[7:0], act_col[7:0], act_col[7:0]};
                default: rgb_c = (act_col[4] ^ act_line[4]) ? 24'hFFFFFF : 24'h000000;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q      <= StIdle;
            col_q        <= '0;
            line_q       <= '0;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            de_o         <= 1'b0;
            red_o        <= '0;
            green_o      <= '0;
            blue_o       <= '0;
            frame_done_o <= 1'b0;
        end else begin
            state_q      <= state_d;
            col_q        <= col_d;
            line_q       <= line_d;
            hsync_o      <= hsync_c;
            vsync_o      <= vsync_c;
            de_o         <= de_c;
            red_o        <= rgb_c[23:16];
            green_o      <= rgb_c[15:8];
            blue_o       <= rgb_c[7:0];
            frame_done_o <= last_pix;
        end
    end

`ifdef VIDEO_SRC_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // Steps on the same edge that raises frame_done_o.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i)        frame_cnt_q <= '0;
        else if (last_pix) frame_cnt_q <= frame_cnt_q + 16'd1;
    end

    assign frame_cnt_o = frame_cnt_q;
`else
    assign frame_cnt_o = 16'd0;
`endif

endmodule

// File: tb/tb_video_src_gen.sv
// Self-checking bench for video_src_gen: a pixel-index reference model predicts
// every output each cycle; scenario tasks add targeted measurements.
module tb_video_src_gen;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        en_i  = 1'b0;
    logic [9:0]  H_sync = '0, H_BP = '0, H_VldDat = '0, H_FP = '0;
    logic [9:0]  V_sync = '0, V_BP = '0, V_VldDat = '0, V_FP = '0;
    logic [1:0]  pattern_sel_i = '0;
    logic [23:0] color_i = '0;
    logic        hsync_o, vsync_o, de_o, frame_done_o;
    logic [7:0]  red_o, green_o, blue_o;
    logic [15:0] frame_cnt_o;

    always #5 clk_i = ~clk_i;

    video_src_gen dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i),
        .H_sync(H_sync), .H_BP(H_BP), .H_VldDat(H_VldDat), .H_FP(H_FP),
        .V_sync(V_sync), .V_BP(V_BP), .V_VldDat(V_VldDat), .V_FP(V_FP),
        .pattern_sel_i(pattern_sel_i), .color_i(color_i),
        .hsync_o(hsync_o), .vsync_o(vsync_o), .de_o(de_o),
        .red_o(red_o), .green_o(green_o), .blue_o(blue_o),
        .frame_done_o(frame_done_o), .frame_cnt_o(frame_cnt_o)
    );

`ifdef VIDEO_SRC_FRAME_CNT_EN
    localparam bit CntEn = 1'b1;
`else
    localparam bit CntEn = 1'b0;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        int hs; int hbp; int hv; int hfp;
        int vs; int vbp; int vv; int vfp;
        logic [1:0]  pat;
        logic [23:0] col;
    } params_t;

    function automatic int frame_len(params_t pr);
        return (pr.hs + pr.hbp + pr.hv + pr.hfp) * (pr.vs + pr.vbp + pr.vv + pr.vfp);
    endfunction

    function automatic logic [23:0] bar_colour(int idx);
        case (idx)
            0:       return 24'hFFFFFF;
            1:       return 24'hFFFF00;
            2:       return 24'h00FFFF;
            3:       return 24'h00FF00;
            4:       return 24'hFF00FF;
            5:       return 24'hFF0000;
            6:       return 24'h0000FF;
            default: return 24'h000000;
        endcase
    endfunction

    // {hsync, vsync, de, rgb} for pixel p of a frame.
    function automatic logic [26:0] model_pixel(params_t pr, int p);
        int ht, c, l, ac, al, bw;
        logic hs, vs, de;
        logic [7:0]  g;
        logic [23:0] rgb;
        ht  = pr.hs + pr.hbp + pr.hv + pr.hfp;
        c   = p % ht;
        l   = p / ht;
        hs  = (c < pr.hs);
        vs  = (l < pr.vs);
        ac  = c - (pr.hs + pr.hbp);
        al  = l - (pr.vs + pr.vbp);
        de  = (ac >= 0) && (ac < pr.hv) && (al >= 0) && (al < pr.vv);
        rgb = '0;
        if (de) begin
            case (pr.pat)
                2'd0: rgb = pr.col;
                2'd1: begin
                    bw  = pr.hv / 8;
                    rgb = (bw == 0) ? 24'h0 : bar_colour(ac / bw);
                end
                2'd2: begin
                    g   = 8'(ac % 256);
                    rgb = {g, g, g};
                end
                default: rgb = ((((ac / 16) ^ (al / 16)) % 2) == 1) ? 24'hFFFFFF : 24'h0;
            endcase
        end
        return {hs, vs, de, rgb};
    endfunction

    params_t     in_par, m_par;
    int          m_p;
    bit          m_gen, m_last;
    logic [15:0] m_cnt;
    logic [43:0] exp_vec;
    wire  [43:0] obs = {hsync_o, vsync_o, de_o, red_o, green_o, blue_o, frame_done_o, frame_cnt_o};

    always_comb begin
        in_par     = '0;
        in_par.hs  = int'(H_sync);
        in_par.hbp = int'(H_BP);
        in_par.hv  = int'(H_VldDat);
        in_par.hfp = int'(H_FP);
        in_par.vs  = int'(V_sync);
        in_par.vbp = int'(V_BP);
        in_par.vv  = int'(V_VldDat);
        in_par.vfp = int'(V_FP);
        in_par.pat = pattern_sel_i;
        in_par.col = color_i;
    end

    always_comb m_last = m_gen && (m_p == frame_len(m_par) - 1);

    // A frame, once started, always completes; en_i only matters at frame boundaries.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_gen   <= 1'b0;
            m_p     <= 0;
            m_cnt   <= '0;
            m_par   <= '0;
            exp_vec <= '0;
        end else begin
            exp_vec <= {(m_gen ? model_pixel(m_par, m_p) : 27'd0), m_last,
                        m_cnt + ((m_last && CntEn) ? 16'd1 : 16'd0)};
            if (m_last && CntEn) m_cnt <= m_cnt + 16'd1;
            if (!m_gen || m_last) begin
                m_par <= in_par;
                m_gen <= en_i && (in_par.hv != 0) && (in_par.vv != 0);
                m_p   <= 0;
            end else begin
                m_p <= m_p + 1;
            end
        end
    end

    task automatic set_params(input int hs, input int hbp, input int hv, input int hfp,
                              input int vs, input int vbp, input int vv, input int vfp,
                              input logic [1:0] pat, input logic [23:0] col);
        H_sync = 10'(hs); H_BP = 10'(hbp); H_VldDat = 10'(hv); H_FP = 10'(hfp);
        V_sync = 10'(vs); V_BP = 10'(vbp); V_VldDat = 10'(vv); V_FP = 10'(vfp);
        pattern_sel_i = pat;
        color_i       = col;
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        rst_i = 1'b0;
        en_i  = 1'b0;
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        set_params(64, 120, 640, 16, 3, 16, 480, 1, 2'd0, 24'hFFFFFF);
        en_i = 1'b1;
        repeat (3) @(negedge clk_i);
        checks++;
        if (obs !== 44'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", obs);
        end
        checks++;
        if (frame_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL reset_frame_cnt: got %h expected 0", frame_cnt_o);
        end
        en_i  = 1'b0;
        rst_i = 1'b1;
        repeat (4) @(negedge clk_i);
        checks++;
        if (obs !== 44'd0) begin
            errors++;
            $display("FAIL idle_outputs: got %h expected 0", obs);
        end
    endtask

    task automatic test_spec_timing();
        int n_hs = 0, n_vs = 0, n_de = 0;
        bit bad = 1'b0;
        set_params(64, 120, 640, 16, 3, 16, 480, 1, 2'd0, 24'hFFFFFF);
        en_i = 1'b1;
        for (int i = 0; i < 21 * 840 + 1; i++) begin
            @(negedge clk_i);
            n_hs += int'(hsync_o);
            n_vs += int'(vsync_o);
            n_de += int'(de_o);
            if (!bad) begin
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL spec_timing cycle %0d: got %h expected %h", i, obs, exp_vec);
                end
            end
        end
        checks++;
        if (n_hs !== 21 * 64) begin
            errors++;
            $display("FAIL spec_hsync_count: got %0d expected %0d", n_hs, 21 * 64);
        end
        checks++;
        if (n_vs !== 3 * 840) begin
            errors++;
            $display("FAIL spec_vsync_count: got %0d expected %0d", n_vs, 3 * 840);
        end
        checks++;
        if (n_de !== 2 * 640) begin
            errors++;
            $display("FAIL spec_de_count: got %0d expected %0d", n_de, 2 * 640);
        end
    endtask

    // Entered while the spec-timing frame is still running.
    task automatic test_reset_mid();
        repeat (100) @(negedge clk_i);
        #2;
        rst_i = 1'b0;
        #1;
        checks++;
        if (obs !== 44'd0) begin
            errors++;
            $display("FAIL reset_mid_async: got %h expected 0", obs);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b1;
        @(posedge clk_i);
        #1;
        checks++;
        if (hsync_o !== 1'b0 || obs !== 44'd0) begin
            errors++;
            $display("FAIL reset_release_edge1: got %h expected 0", obs);
        end
        @(posedge clk_i);
        #1;
        checks++;
        if (hsync_o !== 1'b1 || obs !== exp_vec) begin
            errors++;
            $display("FAIL reset_release_edge2: hsync %b got %h expected %h", hsync_o, obs,
                     exp_vec);
        end
    endtask

    task automatic test_bars();
        int ai = 0;
        bit prev_de = 1'b0, line_done = 1'b0, bad = 1'b0;
        logic [23:0] prev_rgb = '0, first_rgb = 24'hx, last_rgb = 24'hx, cur;
        int edges[$];
        set_params(4, 4, 640, 4, 1, 1, 2, 1, 2'd1, 24'h123456);
        en_i = 1'b1;
        for (int i = 0; i < 652 * 5 + 1; i++) begin
            @(negedge clk_i);
            if (!bad) begin
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL bars cycle %0d: got %h expected %h", i, obs, exp_vec);
                end
            end
            cur = {red_o, green_o, blue_o};
            if (!line_done) begin
                if (de_o) begin
                    if (!prev_de) first_rgb = cur;
                    else if (cur !== prev_rgb) edges.push_back(ai);
                    last_rgb = cur;
                    ai++;
                end else if (prev_de) begin
                    line_done = 1'b1;
                end
            end
            prev_de  = de_o;
            prev_rgb = cur;
        end
        checks++;
        if (edges.size() != 7) begin
            errors++;
            $display("FAIL bar_edge_count: got %0d expected 7", edges.size());
        end else begin
            for (int k = 0; k < 7; k++) begin
                checks++;
                if (edges[k] != 80 * (k + 1)) begin
                    errors++;
                    $display("FAIL bar_edge_%0d: got %0d expected %0d", k, edges[k], 80 * (k + 1));
                end
            end
        end
        checks++;
        if (first_rgb !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL bar_first: got %h expected FFFFFF", first_rgb);
        end
        checks++;
        if (last_rgb !== 24'h000000) begin
            errors++;
            $display("FAIL bar_last: got %h expected 000000", last_rgb);
        end
    endtask

    task automatic test_gradient();
        int ai = 0;
        bit bad = 1'b0;
        logic [23:0] at0 = 24'hx, at255 = 24'hx, at256 = 24'hx;
        set_params(2, 2, 300, 2, 1, 1, 2, 1, 2'd2, 24'h0);
        en_i = 1'b1;
        for (int i = 0; i < 306 * 5 + 1; i++) begin
            @(negedge clk_i);
            if (!bad) begin
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL gradient cycle %0d: got %h expected %h", i, obs, exp_vec);
                end
            end
            if (de_o) begin
                if (ai == 0)   at0   = {red_o, green_o, blue_o};
                if (ai == 255) at255 = {red_o, green_o, blue_o};
                if (ai == 256) at256 = {red_o, green_o, blue_o};
                ai++;
            end else begin
                ai = 0;
            end
        end
        checks++;
        if (at0 !== 24'h000000) begin
            errors++;
            $display("FAIL grad_col0: got %h expected 000000", at0);
        end
        checks++;
        if (at255 !== 24'hFFFFFF) begin
            errors++;
            $display("FAIL grad_col255: got %h expected FFFFFF", at255);
        end
        checks++;
        if (at256 !== 24'h000000) begin
            errors++;
            $display("FAIL grad_col256: got %h expected 000000", at256);
        end
    endtask

    // Checker pattern while H_VldDat changes 640 -> 320 before the first active line.
    task automatic test_mid_change();
        int run_len = 0;
        int widths[$];
        bit bad = 1'b0;
        set_params(4, 4, 640, 4, 1, 1, 3, 1, 2'd3, 24'h0);
        en_i = 1'b1;
        for (int i = 0; i < 5580; i++) begin
            @(negedge clk_i);
            if (!bad) begin
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL mid_change cycle %0d: got %h expected %h", i, obs, exp_vec);
                end
            end
            if (de_o) begin
                run_len++;
            end else if (run_len > 0) begin
                widths.push_back(run_len);
                run_len = 0;
            end
            if (i == 1000) H_VldDat = 10'd320;
        end
        checks++;
        if (widths.size() != 6) begin
            errors++;
            $display("FAIL mid_change_lines: got %0d expected 6", widths.size());
        end else begin
            for (int k = 0; k < 6; k++) begin
                checks++;
                if (widths[k] != ((k < 3) ? 640 : 320)) begin
                    errors++;
                    $display("FAIL mid_change_width_%0d: got %0d expected %0d", k, widths[k],
                             (k < 3) ? 640 : 320);
                end
            end
        end
    endtask

    task automatic test_en_drop();
        int n_fd = 0;
        bit bad = 1'b0;
        logic [15:0] exp_fc;
        exp_fc = CntEn ? 16'd1 : 16'd0;
        set_params(2, 2, 8, 2, 3, 16, 120, 1, 2'(($urandom_range(0, 3))), 24'($urandom));
        en_i = 1'b1;
        for (int i = 0; i < 2100; i++) begin
            @(negedge clk_i);
            if (!bad) begin
                checks++;
                if (obs !== exp_vec) begin
                    errors++;
                    bad = 1'b1;
                    $display("FAIL en_drop cycle %0d: got %h expected %h", i, obs, exp_vec);
                end
            end
            n_fd += int'(frame_done_o);
            if (i == 100 * 14 + 1) en_i = 1'b0;
        end
        checks++;
        if (n_fd != 1) begin
            errors++;
            $display("FAIL en_drop_frames: got %0d expected 1", n_fd);
        end
        checks++;
        if (obs[43:16] !== 28'd0) begin
            errors++;
            $display("FAIL en_drop_idle_outputs: got %h expected 0", obs[43:16]);
        end
        checks++;
        if (frame_cnt_o !== exp_fc) begin
            errors++;
            $display("FAIL en_drop_frame_cnt: got %0d expected %0d", frame_cnt_o, exp_fc);
        end
    endtask

    task automatic test_zero_active();
        bit bad = 1'b0;
        for (int s = 0; s < 2; s++) begin
            if (s == 0) set_params(2, 2, 0, 2, 1, 1, 5, 1, 2'd0, 24'hFFFFFF);
            else        set_params(2, 2, 5, 2, 1, 1, 0, 1, 2'd0, 24'hFFFFFF);
            en_i = 1'b1;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk_i);
                if (!bad) begin
                    checks++;
                    if (obs !== 44'd0) begin
                        errors++;
                        bad = 1'b1;
                        $display("FAIL zero_active set %0d cycle %0d: got %h expected 0", s, i,
                                 obs);
                    end
                end
            end
        end
        en_i = 1'b0;
    endtask

    task automatic test_random();
        params_t pr;
        int total, bound;
        for (int n = 0; n < 5; n++) begin
            int fd_at[$];
            bit bad = 1'b0;
            pr     = '0;
            pr.hs  = $urandom_range(0, 5);
            pr.hbp = $urandom_range(0, 5);
            pr.hv  = $urandom_range(1, 24);
            pr.hfp = $urandom_range(0, 5);
            pr.vs  = $urandom_range(0, 5);
            pr.vbp = $urandom_range(0, 5);
            pr.vv  = $urandom_range(1, 24);
            pr.vfp = $urandom_range(0, 5);
            pr.pat = 2'($urandom_range(0, 3));
            pr.col = 24'($urandom);
            set_params(pr.hs, pr.hbp, pr.hv, pr.hfp, pr.vs, pr.vbp, pr.vv, pr.vfp, pr.pat,
                       pr.col);
            total = frame_len(pr);
            bound = 2 * total + 20;
            en_i  = 1'b1;
            for (int i = 0; i < bound; i++) begin
                @(negedge clk_i);
                if (!bad) begin
                    checks++;
                    if (obs !== exp_vec) begin
                        errors++;
                        bad = 1'b1;
                        $display("FAIL random set %0d cycle %0d: got %h expected %h", n, i, obs,
                                 exp_vec);
                    end
                end
                if (frame_done_o === 1'b1) fd_at.push_back(i);
                if (fd_at.size() == 2) break;
                // Brief enable drop mid-frame must not disturb generation.
                if (total > 8 && i == total / 2)     en_i = 1'b0;
                if (total > 8 && i == total / 2 + 3) en_i = 1'b1;
            end
            checks++;
            if (fd_at.size() != 2) begin
                errors++;
                $display("FAIL random_timeout set %0d: got %0d frame_done pulses expected 2", n,
                         fd_at.size());
            end else begin
                checks++;
                if (fd_at[1] - fd_at[0] != total) begin
                    errors++;
                    $display("FAIL random_period set %0d: got %0d expected %0d", n,
                             fd_at[1] - fd_at[0], total);
                end
            end
            do_reset();
        end
    endtask

    initial begin
        test_reset();
        test_spec_timing();
        test_reset_mid();
        do_reset();
        test_bars();
        do_reset();
        test_gradient();
        do_reset();
        test_mid_change();
        do_reset();
        test_en_drop();
        do_reset();
        test_zero_active();
        do_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
